// File: rtl/sram_responder_if.sv
// Address and write-strobe side of the external 16-bit SRAM bus.
// Signals:
//   SRAM_ADDR  18-bit word address from the initiator
//   SRAM_WE_N  active-low write strobe
// The data bus SRAM_DQ is bidirectional and is a plain inout port on the
// responder, so the bidirectional net resolves at the module boundary.
interface sram_responder_if;
    logic [17:0] SRAM_ADDR;
    logic        SRAM_WE_N;

    modport master (output SRAM_ADDR, output SRAM_WE_N);
    modport slave  (input  SRAM_ADDR, input  SRAM_WE_N);
endinterface

// File: rtl/sram_responder.sv
// Responder for the external 16-bit SRAM bus. It stores bus writes and returns
// read data once the address has been held stable for READ_LAT edges. DQ is
// tri-stated whenever read data is not being returned. A debug port provides
// preload and inspection, and there are saturating access counters.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   bus            SRAM_ADDR / SRAM_WE_N from the initiator (slave modport)
//   SRAM_DQ        bidirectional 16-bit data bus
//   dbg_we/addr/wdata  debug write; dropped when a bus write shares the edge
//   dbg_rdata      mem[dbg_addr], registered, shows the pre-write value
//   dbg_collision  one-cycle pulse when a debug write was dropped
//   wr_cnt/rd_cnt  saturating counts of bus writes and completed reads
module sram_responder #(
    parameter int unsigned MEM_AW   = 16,
    parameter int unsigned READ_LAT = 2
) (
    input  logic                clk,
    input  logic                rst,
    sram_responder_if.slave     bus,
    inout  wire  [15:0]         SRAM_DQ,
    input  logic                dbg_we,
    input  logic [MEM_AW-1:0]   dbg_addr,
    input  logic [15:0]         dbg_wdata,
    output logic [15:0]         dbg_rdata,
    output logic                dbg_collision,
    output logic [15:0]         wr_cnt,
    output logic [15:0]         rd_cnt
);

    localparam int unsigned DW    = 16;
    localparam int unsigned CW    = 4;
    localparam int unsigned AW    = 18;
    localparam int unsigned DEPTH = 2 ** MEM_AW;
    localparam logic [CW-1:0] LAT = CW'(READ_LAT);

    logic [DW-1:0] mem [DEPTH];

    logic          oe;
    logic [CW-1:0] cnt;
    logic          addr_vld;
    logic [AW-1:0] last_addr;
    logic [DW-1:0] rdata;

    logic          oe_nxt;
    logic [CW-1:0] cnt_nxt;
    logic          addr_vld_nxt;
    logic [AW-1:0] last_addr_nxt;

    logic              bus_wr_c;
    logic [MEM_AW-1:0] bus_idx_c;

    assign bus_wr_c  = !bus.SRAM_WE_N;
    // Upper address bits beyond MEM_AW alias onto the implemented depth.
    assign bus_idx_c = bus.SRAM_ADDR[MEM_AW-1:0];

    // Gate on WE_N directly so DQ releases in the same cycle a write starts.
    assign SRAM_DQ = (oe && bus.SRAM_WE_N) ? rdata : {DW{1'bz}};

    // Read latency tracking: write, new address, or stable address.
    always_comb begin
        oe_nxt        = oe;
        cnt_nxt       = cnt;
        addr_vld_nxt  = addr_vld;
        last_addr_nxt = last_addr;
        if (bus_wr_c) begin
            oe_nxt       = 1'b0;
            cnt_nxt      = '0;
            addr_vld_nxt = 1'b0;
        end else if (!addr_vld || (bus.SRAM_ADDR != last_addr)) begin
            last_addr_nxt = bus.SRAM_ADDR;
            addr_vld_nxt  = 1'b1;
            cnt_nxt       = '0;
            oe_nxt        = (LAT == '0);
        end else begin
            // cnt never exceeds LAT, so equality marks the latency reached.
            cnt_nxt = (cnt == LAT) ? LAT : cnt + CW'(1);
            oe_nxt  = (cnt_nxt == LAT);
        end
    end

    // Control, read data, debug readback and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            oe            <= 1'b0;
            cnt           <= '0;
            addr_vld      <= 1'b0;
            last_addr     <= '0;
            rdata         <= '0;
            dbg_rdata     <= '0;
            dbg_collision <= 1'b0;
            wr_cnt        <= '0;
            rd_cnt        <= '0;
        end else begin
            oe            <= oe_nxt;
            cnt           <= cnt_nxt;
            addr_vld      <= addr_vld_nxt;
            last_addr     <= last_addr_nxt;
            if (oe_nxt) begin
                rdata <= mem[bus_idx_c];
            end
            dbg_rdata     <= mem[dbg_addr];
            dbg_collision <= dbg_we && bus_wr_c;
            if (bus_wr_c && (wr_cnt != '1)) begin
                wr_cnt <= wr_cnt + 16'(1);
            end
            if (oe_nxt && !oe && (rd_cnt != '1)) begin
                rd_cnt <= rd_cnt + 16'(1);
            end
        end
    end

    // Storage is never cleared; a bus write takes the port over a debug write.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (bus_wr_c) begin
                mem[bus_idx_c] <= SRAM_DQ;
            end else if (dbg_we) begin
                mem[dbg_addr] <= dbg_wdata;
            end
        end
    end

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: one READ_LAT=2 and one READ_LAT=0 instance share
// the same stimulus and are checked against a cycle model that tracks how many
// consecutive edges each address has been held.
module tb_sram_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [17:0] addr = '0;
    logic        we_n = 1'b1;
    logic        drv_en = 1'b0;
    logic [15:0] drv_val = '0;
    logic        dbg_we = 1'b0;
    logic [15:0] dbg_addr = '0;
    logic [15:0] dbg_wdata = '0;

    always #5 clk = ~clk;

    // Undriven data bus floats high, so "released" reads as 16'hFFFF.
    tri1 [15:0] dq_a;
    tri1 [15:0] dq_b;
    assign dq_a = drv_en ? drv_val : 16'hzzzz;
    assign dq_b = drv_en ? drv_val : 16'hzzzz;

    sram_responder_if ifa ();
    sram_responder_if ifb ();
    assign ifa.SRAM_ADDR = addr;
    assign ifa.SRAM_WE_N = we_n;
    assign ifb.SRAM_ADDR = addr;
    assign ifb.SRAM_WE_N = we_n;

    logic [15:0] dbg_rdata_o [2];
    logic        col_o       [2];
    logic [15:0] wr_cnt_o    [2];
    logic [15:0] rd_cnt_o    [2];

    sram_responder #(.MEM_AW(16), .READ_LAT(2)) u_lat2 (
        .clk(clk), .rst(rst), .bus(ifa), .SRAM_DQ(dq_a),
        .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata_o[0]), .dbg_collision(col_o[0]),
        .wr_cnt(wr_cnt_o[0]), .rd_cnt(rd_cnt_o[0])
    );

    sram_responder #(.MEM_AW(16), .READ_LAT(0)) u_lat0 (
        .clk(clk), .rst(rst), .bus(ifb), .SRAM_DQ(dq_b),
        .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_rdata(dbg_rdata_o[1]), .dbg_collision(col_o[1]),
        .wr_cnt(wr_cnt_o[1]), .rd_cnt(rd_cnt_o[1])
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state, one copy per instance.
    logic [15:0] m_mem [2][65536];
    int          run [2] = '{0, 0};
    logic [17:0] m_last [2];
    logic [15:0] m_rdata [2];
    logic [15:0] m_dbg_rdata [2];
    logic [15:0] m_wr [2];
    logic [15:0] m_rd [2];
    logic        m_col [2];

    function automatic int lat_of(int d);
        return (d == 0) ? 2 : 0;
    endfunction

    function automatic logic [15:0] dq_obs(int d);
        return (d == 0) ? dq_a : dq_b;
    endfunction

    // Expected resolved bus value right now.
    function automatic logic [15:0] exp_net(int d);
        if (drv_en) return drv_val;
        if (we_n && (run[d] >= lat_of(d) + 1)) return m_rdata[d];
        return 16'hFFFF;
    endfunction

    function automatic logic [15:0] rnd16();
        logic [15:0] v;
        v = 16'($urandom);
        if (v == 16'hFFFF) v = 16'h0000;
        return v;
    endfunction

    // One clock edge of the model: read data is returned once an address has
    // been sampled READ_LAT+1 times in a row without an intervening write.
    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            logic was_drv;
            logic now_drv;
            was_drv = (run[d] >= lat_of(d) + 1);
            if (rst) begin
                run[d] = 0;
                m_rdata[d] = '0;
                m_dbg_rdata[d] = '0;
                m_wr[d] = '0;
                m_rd[d] = '0;
                m_col[d] = 1'b0;
            end else begin
                m_dbg_rdata[d] = m_mem[d][dbg_addr];
                m_col[d] = dbg_we && !we_n;
                if (!we_n) begin
                    run[d] = 0;
                    m_mem[d][addr[15:0]] = drv_val;
                    if (m_wr[d] != 16'hFFFF) m_wr[d] = m_wr[d] + 16'd1;
                end else begin
                    if (run[d] > 0 && addr == m_last[d]) begin
                        if (run[d] < 100) run[d] = run[d] + 1;
                    end else begin
                        run[d] = 1;
                    end
                    m_last[d] = addr;
                    now_drv = (run[d] >= lat_of(d) + 1);
                    if (now_drv) m_rdata[d] = m_mem[d][addr[15:0]];
                    if (now_drv && !was_drv && m_rd[d] != 16'hFFFF) m_rd[d] = m_rd[d] + 16'd1;
                    if (dbg_we) m_mem[d][dbg_addr] = dbg_wdata;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_preload();
        rst = 1'b0;
        we_n = 1'b1;
        addr = 18'h3FFFF;
        for (int i = 0; i < 64; i++) begin
            dbg_we = 1'b1;
            dbg_addr = 16'(i);
            dbg_wdata = rnd16();
            tick();
        end
        dbg_we = 1'b0;
        for (int i = 0; i < 4; i++) begin
            dbg_addr = 16'(i * 17);
            tick();
            for (int d = 0; d < 2; d++) begin
                n_cmp++;
                if (dbg_rdata_o[d] !== m_mem[d][16'(i * 17)]) begin
                    n_err++;
                    $display("FAIL preload dut%0d addr %0d: got %h want %h", d, i * 17, dbg_rdata_o[d], m_mem[d][16'(i * 17)]);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        addr = '0;
        we_n = 1'b1;
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (dq_obs(d) !== 16'hFFFF || wr_cnt_o[d] !== 16'd0 || rd_cnt_o[d] !== 16'd0 ||
                dbg_rdata_o[d] !== 16'd0 || col_o[d] !== 1'b0) begin
                n_err++;
                $display("FAIL reset_state dut%0d: got dq=%h wr=%h rd=%h dbg=%h col=%b want ffff/0/0/0/0",
                         d, dq_obs(d), wr_cnt_o[d], rd_cnt_o[d], dbg_rdata_o[d], col_o[d]);
            end
        end
        rst = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            logic [15:0] want0;
            logic [15:0] want1;
            tick();
            want0 = (e < 3) ? 16'hFFFF : m_mem[0][0];
            want1 = m_mem[1][0];
            n_cmp++;
            if (dq_a !== want0) begin
                n_err++;
                $display("FAIL reset_release_lat2 edge %0d: got %h want %h", e, dq_a, want0);
            end
            n_cmp++;
            if (dq_b !== want1) begin
                n_err++;
                $display("FAIL reset_release_lat0 edge %0d: got %h want %h", e, dq_b, want1);
            end
        end
        n_cmp++;
        if (rd_cnt_o[0] !== 16'd1) begin
            n_err++;
            $display("FAIL reset_rd_cnt: got %h want 0001", rd_cnt_o[0]);
        end
        // Reset while driving releases DQ on the next edge.
        rst = 1'b1;
        tick();
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (dq_obs(d) !== 16'hFFFF) begin
                n_err++;
                $display("FAIL reset_mid_read dut%0d: got %h want ffff", d, dq_obs(d));
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_write_read();
        do_reset();
        addr = 18'h00010;
        we_n = 1'b0;
        drv_en = 1'b1;
        drv_val = 16'hA5A5;
        tick();
        we_n = 1'b1;
        drv_en = 1'b0;
        for (int e = 1; e <= 3; e++) begin
            logic [15:0] want;
            tick();
            want = (e < 3) ? 16'hFFFF : 16'hA5A5;
            n_cmp++;
            if (dq_a !== want) begin
                n_err++;
                $display("FAIL write_read edge %0d: got %h want %h", e, dq_a, want);
            end
        end
        n_cmp++;
        if (wr_cnt_o[0] !== 16'd1 || rd_cnt_o[0] !== 16'd1) begin
            n_err++;
            $display("FAIL write_read_counts: got wr=%h rd=%h want 0001/0001", wr_cnt_o[0], rd_cnt_o[0]);
        end
        n_cmp++;
        if (dq_b !== 16'hA5A5) begin
            n_err++;
            $display("FAIL write_read_lat0: got %h want a5a5", dq_b);
        end
    endtask

    task automatic test_addr_toggle();
        do_reset();
        we_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            addr = (i % 2 == 1) ? 18'h00011 : 18'h00010;
            tick();
            n_cmp++;
            if (dq_a !== 16'hFFFF || rd_cnt_o[0] !== 16'd0) begin
                n_err++;
                $display("FAIL toggle edge %0d: got dq=%h rd=%h want ffff/0000", i, dq_a, rd_cnt_o[0]);
            end
            n_cmp++;
            if (dq_b !== exp_net(1) || rd_cnt_o[1] !== m_rd[1]) begin
                n_err++;
                $display("FAIL toggle_lat0 edge %0d: got dq=%h rd=%h want %h/%h", i, dq_b, rd_cnt_o[1], exp_net(1), m_rd[1]);
            end
        end
        addr = 18'h00011;
        for (int e = 1; e <= 3; e++) begin
            logic [15:0] want;
            tick();
            want = (e < 3) ? 16'hFFFF : m_mem[0][16'h0011];
            n_cmp++;
            if (dq_a !== want) begin
                n_err++;
                $display("FAIL toggle_hold edge %0d: got %h want %h", e, dq_a, want);
            end
        end
        n_cmp++;
        if (rd_cnt_o[0] !== 16'd1) begin
            n_err++;
            $display("FAIL toggle_rd_cnt: got %h want 0001", rd_cnt_o[0]);
        end
    endtask

    task automatic test_write_during_read();
        do_reset();
        addr = 18'h00010;
        we_n = 1'b1;
        repeat (3) tick();
        n_cmp++;
        if (dq_a !== m_mem[0][16'h0010]) begin
            n_err++;
            $display("FAIL wdr_drive: got %h want %h", dq_a, m_mem[0][16'h0010]);
        end
        we_n = 1'b0;
        drv_en = 1'b1;
        drv_val = 16'h1234;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (dq_obs(d) !== 16'h1234) begin
                n_err++;
                $display("FAIL wdr_release dut%0d: got %h want 1234", d, dq_obs(d));
            end
        end
        tick();
        we_n = 1'b1;
        drv_en = 1'b0;
        repeat (3) tick();
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (dq_obs(d) !== 16'h1234) begin
                n_err++;
                $display("FAIL wdr_readback dut%0d: got %h want 1234", d, dq_obs(d));
            end
        end
    endtask

    task automatic test_collision();
        logic [15:0] old20;
        do_reset();
        old20 = m_mem[0][16'h0020];
        dbg_we = 1'b1;
        dbg_addr = 16'h0020;
        dbg_wdata = 16'hBEEF;
        we_n = 1'b0;
        drv_en = 1'b1;
        addr = 18'h00030;
        drv_val = 16'hCAFE;
        tick();
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (col_o[d] !== 1'b1) begin
                n_err++;
                $display("FAIL collision_pulse dut%0d: got %b want 1", d, col_o[d]);
            end
        end
        dbg_we = 1'b0;
        we_n = 1'b1;
        drv_en = 1'b0;
        dbg_addr = 16'h0030;
        tick();
        n_cmp++;
        if (col_o[0] !== 1'b0 || dbg_rdata_o[0] !== 16'hCAFE) begin
            n_err++;
            $display("FAIL collision_after: got col=%b dbg=%h want 0/cafe", col_o[0], dbg_rdata_o[0]);
        end
        dbg_addr = 16'h0020;
        tick();
        n_cmp++;
        if (dbg_rdata_o[0] !== old20) begin
            n_err++;
            $display("FAIL collision_dropped: got %h want %h", dbg_rdata_o[0], old20);
        end
        dbg_we = 1'b1;
        dbg_wdata = 16'hBEEF;
        tick();
        n_cmp++;
        if (dbg_rdata_o[0] !== old20 || col_o[0] !== 1'b0) begin
            n_err++;
            $display("FAIL dbg_write_prewrite: got dbg=%h col=%b want %h/0", dbg_rdata_o[0], col_o[0], old20);
        end
        dbg_we = 1'b0;
        tick();
        n_cmp++;
        if (dbg_rdata_o[0] !== 16'hBEEF) begin
            n_err++;
            $display("FAIL dbg_write_visible: got %h want beef", dbg_rdata_o[0]);
        end
    endtask

    task automatic test_lat0_alias();
        do_reset();
        we_n = 1'b1;
        addr = 18'h10005;
        tick();
        n_cmp++;
        if (dq_b !== m_mem[1][16'h0005] || rd_cnt_o[1] !== 16'd1) begin
            n_err++;
            $display("FAIL lat0_alias: got dq=%h rd=%h want %h/0001", dq_b, rd_cnt_o[1], m_mem[1][16'h0005]);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            int r;
            r = int'($urandom_range(0, 99));
            rst = (r < 2);
            if (r >= 2 && r < 22) begin
                we_n = 1'b0;
                drv_en = 1'b1;
                drv_val = rnd16();
                addr = {2'($urandom), 10'd0, 6'($urandom)};
            end else begin
                we_n = 1'b1;
                drv_en = 1'b0;
                if (r >= 70) addr = {2'($urandom), 10'd0, 6'($urandom)};
            end
            dbg_we = ($urandom_range(0, 99) < 15);
            dbg_addr = 16'($urandom_range(0, 63));
            dbg_wdata = rnd16();
            #1;
            for (int d = 0; d < 2; d++) begin
                n_cmp++;
                if (dq_obs(d) !== exp_net(d)) begin
                    n_err++;
                    $display("FAIL rand_comb c%0d dut%0d: got %h want %h", c, d, dq_obs(d), exp_net(d));
                end
            end
            tick();
            for (int d = 0; d < 2; d++) begin
                n_cmp++;
                if (dq_obs(d) !== exp_net(d) || wr_cnt_o[d] !== m_wr[d] || rd_cnt_o[d] !== m_rd[d] ||
                    col_o[d] !== m_col[d] || dbg_rdata_o[d] !== m_dbg_rdata[d]) begin
                    n_err++;
                    $display("FAIL rand c%0d dut%0d: got dq=%h wr=%h rd=%h col=%b dbg=%h want %h/%h/%h/%b/%h",
                             c, d, dq_obs(d), wr_cnt_o[d], rd_cnt_o[d], col_o[d], dbg_rdata_o[d],
                             exp_net(d), m_wr[d], m_rd[d], m_col[d], m_dbg_rdata[d]);
                end
            end
        end
        rst = 1'b0;
        we_n = 1'b1;
        drv_en = 1'b0;
        dbg_we = 1'b0;
    endtask

    task automatic test_saturate();
        do_reset();
        dbg_we = 1'b0;
        we_n = 1'b0;
        drv_en = 1'b1;
        addr = 18'h00100;
        for (int i = 0; i < 65536; i++) begin
            drv_val = 16'(i);
            tick();
            if (i == 65533) begin
                n_cmp++;
                if (wr_cnt_o[0] !== 16'hFFFE) begin
                    n_err++;
                    $display("FAIL saturate_pre: got %h want fffe", wr_cnt_o[0]);
                end
            end
        end
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (wr_cnt_o[d] !== 16'hFFFF || wr_cnt_o[d] !== m_wr[d]) begin
                n_err++;
                $display("FAIL saturate dut%0d: got %h want ffff", d, wr_cnt_o[d]);
            end
        end
        we_n = 1'b1;
        drv_en = 1'b0;
    endtask

    initial begin
        repeat (2) tick();
        test_preload();
        test_reset();
        test_write_read();
        test_addr_toggle();
        test_write_during_read();
        test_collision();
        test_lat0_alias();
        test_random();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
